modbus_tx_frame_builder: RTL

//  Downstream of the Modbus function handler. On handler_done, builds the RTU response frame:

---
 rtl/modbus_tx_frame_builder_if.sv | 10 +
 rtl/modbus_tx_frame_builder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/modbus_tx_frame_builder_if.sv
// Byte-stream link from the frame builder to the UART TX stage.
// The builder drives data/valid and the consumer drives ready.
interface modbus_tx_frame_builder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/modbus_tx_frame_builder.sv
// Builds a Modbus RTU response frame (address, function, payload, CRC16)
// and streams it byte by byte over a valid/ready link.
module modbus_tx_frame_builder #(
  parameter int unsigned MAX_QTY = 125
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      dev_addr,
  input  logic                            handler_done,
  input  logic [7:0]                      func_code,
  input  logic [15:0]                     addr,
  input  logic [15:0]                     data,
  input  logic [7:0]                      exception_code,
  input  logic [7:0]                      tx_quantity,
  output logic [7:0]                      dpram_raddr,
  input  logic [15:0]                     dpram_rdata,
  modbus_tx_frame_builder_if.master       tx,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic                            drop_err
);

  localparam logic [7:0] MAX_QTY_B = 8'(MAX_QTY);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, HDR2, RD_ADDR, RD_WAIT, D_HI, D_LO, E06, CRC_LO, CRC_HI, DONE
  } state_e;

  typedef enum logic [1:0] {K_EXC, K_READ, K_ECHO} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d, kind_dec;
  logic [7:0]  dev_q, dev_d;
  logic [7:0]  b1_q, b1_d, b1_dec;
  logic [7:0]  b2_q, b2_d, b2_dec;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic [7:0]  qty_q, qty_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic [15:0] crc_q, crc_d;
  logic        drop_q, drop_d;
  logic        valid_c, accept;
  logic [7:0]  byte_c;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Frame type is decided once at latch time so the FSM only walks byte slots.
  always_comb begin
    kind_dec = K_EXC;
    b1_dec   = func_code | 8'h80;
    b2_dec   = 8'h01;
    if (exception_code != 8'h00) begin
      b2_dec = exception_code;
    end else if (func_code == 8'h03 || func_code == 8'h04) begin
      if (tx_quantity == 8'h00 || tx_quantity > MAX_QTY_B) begin
        b2_dec = 8'h03;
      end else begin
        kind_dec = K_READ;
        b1_dec   = func_code;
        b2_dec   = {tx_quantity[6:0], 1'b0};
      end
    end else if (func_code == 8'h06) begin
      kind_dec = K_ECHO;
      b1_dec   = func_code;
      b2_dec   = 8'h00;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    kind_d  = kind_q;
    dev_d   = dev_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    addr_d  = addr_q;
    data_d  = data_q;
    qty_d   = qty_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    crc_d   = crc_q;
    drop_d  = 1'b0;
    byte_c  = 8'h00;
    valid_c = state_q inside {HDR0, HDR1, HDR2, D_HI, D_LO, E06, CRC_LO, CRC_HI};

    unique case (state_q)
      HDR0:   byte_c = dev_q;
      HDR1:   byte_c = b1_q;
      HDR2:   byte_c = b2_q;
      D_HI:   byte_c = word_q[15:8];
      D_LO:   byte_c = word_q[7:0];
      E06: begin
        unique case (cnt_q)
          2'd0: byte_c = addr_q[15:8];
          2'd1: byte_c = addr_q[7:0];
          2'd2: byte_c = data_q[15:8];
          default: byte_c = data_q[7:0];
        endcase
      end
      CRC_LO: byte_c = crc_q[7:0];
      CRC_HI: byte_c = crc_q[15:8];
      default: byte_c = 8'h00;
    endcase

    accept = valid_c && tx.tx_ready;
    if (accept && state_q != CRC_LO && state_q != CRC_HI) crc_d = crc16_byte(crc_q, byte_c);

    unique case (state_q)
      HDR0:    if (accept) state_d = HDR1;
      HDR1:    if (accept) state_d = (kind_q == K_ECHO) ? E06 : HDR2;
      HDR2:    if (accept) state_d = (kind_q == K_READ) ? RD_ADDR : CRC_LO;
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d  = dpram_rdata;
        state_d = D_HI;
      end
      D_HI:    if (accept) state_d = D_LO;
      D_LO: begin
        if (accept) begin
          if (idx_q == qty_q - 8'd1) begin
            state_d = CRC_LO;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = RD_ADDR;
          end
        end
      end
      E06: begin
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = CRC_LO;
        end
      end
      CRC_LO:  if (accept) state_d = CRC_HI;
      CRC_HI:  if (accept) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (handler_done) begin
      if (state_q == IDLE || state_q == DONE) begin
        kind_d  = kind_dec;
        dev_d   = dev_addr;
        b1_d    = b1_dec;
        b2_d    = b2_dec;
        addr_d  = addr;
        data_d  = data;
        qty_d   = tx_quantity;
        idx_d   = 8'd0;
        cnt_d   = 2'd0;
        crc_d   = 16'hFFFF;
        state_d = HDR0;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; all state uses non-blocking assignments.
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= K_EXC;
      dev_q   <= 8'h00;
      b1_q    <= 8'h00;
      b2_q    <= 8'h00;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      qty_q   <= 8'h00;
      idx_q   <= 8'h00;
      cnt_q   <= 2'd0;
      word_q  <= 16'h0000;
      crc_q   <= 16'hFFFF;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      dev_q   <= dev_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      qty_q   <= qty_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      crc_q   <= crc_d;
      drop_q  <= drop_d;
    end
  end

  assign tx.tx_data  = byte_c;
  assign tx.tx_valid = valid_c;
  assign tx_busy     = (state_q != IDLE) && (state_q != DONE);
  assign tx_done     = (state_q == DONE);
  assign drop_err    = drop_q;
  assign dpram_raddr = idx_q;

endmodule
